thread_register_file: RTL and testbench

//  Per-thread scalar + vector register file feeding the ALU operand ports (rs/rt, v_rs/v_rt) and

---
 rtl/thread_register_file.sv | 164 ++++++++++++++++
 tb/tb_thread_register_file.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/thread_register_file.sv
// Per-thread scalar + vector register file for one thread lane.
// R0..R12 are general purpose, R13 mirrors block_id, and R14/R15 are read-only constants.
// Operands are latched in REQUEST and writebacks land in UPDATE.
module thread_register_file #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_ID         = 0,
  parameter int Vector_Size       = 4,
  parameter int NUM_VREGS         = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [7:0]               block_id,
  input  logic [2:0]               core_state,
  input  logic [3:0]               decoded_rd_address,
  input  logic [3:0]               decoded_rs_address,
  input  logic [3:0]               decoded_rt_address,
  input  logic                     decoded_reg_write_enable,
  input  logic [1:0]               decoded_reg_input_mux,
  input  logic [7:0]               decoded_immediate,
  input  logic                     decoded_vreg_write_enable,
  input  logic                     decoded_vreg_input_mux,
  input  logic [7:0]               alu_out,
  input  logic [7:0]               lsu_out,
  input  logic [8*Vector_Size-1:0] v_alu_out,
  input  logic [8*Vector_Size-1:0] v_lsu_out,
  output logic [7:0]               rs,
  output logic [7:0]               rt,
  output logic [8*Vector_Size-1:0] v_rs,
  output logic [8*Vector_Size-1:0] v_rt
);

  localparam int VEC_W = 8 * Vector_Size;
  localparam int VA_W  = $clog2(NUM_VREGS);
  localparam int NUM_GPR = 13;

  localparam logic [2:0] ST_REQUEST = 3'b011;
  localparam logic [2:0] ST_UPDATE  = 3'b110;

  localparam logic [7:0] TPB_VAL = 8'(THREADS_PER_BLOCK);
  localparam logic [7:0] TID_VAL = 8'(THREAD_ID);

  // Architectural state
  logic [7:0]       gpr_reg  [0:NUM_GPR-1];
  logic [7:0]       bid_reg;
  logic [VEC_W-1:0] vreg_reg [0:NUM_VREGS-1];

  // Registered operand outputs
  logic [7:0]       rs_reg, rt_reg;
  logic [VEC_W-1:0] v_rs_reg, v_rt_reg;

  // Combinational read selections and writeback controls
  logic [7:0]         rs_next, rt_next;
  logic [VEC_W-1:0]   v_rs_next, v_rt_next;
  logic [7:0]         wb_data;
  logic               wb_valid;
  logic [VEC_W-1:0]   vwb_data;
  logic               read_fire;
  logic               update_fire;
  logic [NUM_GPR-1:0] gpr_wr_sel;
  logic [NUM_VREGS-1:0] vreg_wr_sel;

  logic [VA_W-1:0] vd_index, vs_index, vt_index;

  assign read_fire   = enable && (core_state == ST_REQUEST);
  assign update_fire = enable && (core_state == ST_UPDATE);

  assign vd_index = decoded_rd_address[VA_W-1:0];
  assign vs_index = decoded_rs_address[VA_W-1:0];
  assign vt_index = decoded_rt_address[VA_W-1:0];

  // Scalar source operand selection; upper addresses map onto the special registers
  always_comb begin
    rs_next = 8'h00;
    rt_next = 8'h00;
    case (decoded_rs_address)
      4'd13:   rs_next = bid_reg;
      4'd14:   rs_next = TPB_VAL;
      4'd15:   rs_next = TID_VAL;
      default: rs_next = gpr_reg[decoded_rs_address];
    endcase
    case (decoded_rt_address)
      4'd13:   rt_next = bid_reg;
      4'd14:   rt_next = TPB_VAL;
      4'd15:   rt_next = TID_VAL;
      default: rt_next = gpr_reg[decoded_rt_address];
    endcase
  end

  // Vector source operand selection; only the low address bits name a vector register
  always_comb begin
    v_rs_next = vreg_reg[vs_index];
    v_rt_next = vreg_reg[vt_index];
  end

  // Writeback source mux; the reserved mux code and special registers suppress the write
  always_comb begin
    wb_data  = 8'h00;
    wb_valid = decoded_reg_write_enable && (decoded_rd_address < 4'd13);
    case (decoded_reg_input_mux)
      2'b00:   wb_data = alu_out;
      2'b01:   wb_data = lsu_out;
      2'b10:   wb_data = decoded_immediate;
      default: wb_valid = 1'b0;
    endcase
    vwb_data = decoded_vreg_input_mux ? v_lsu_out : v_alu_out;
  end

  // Per-register write strobes for the scalar file
  genvar gi;
  generate
    for (gi = 0; gi < NUM_GPR; gi++) begin : g_gpr_sel
      assign gpr_wr_sel[gi] = update_fire && wb_valid && (decoded_rd_address == 4'(gi));
    end
    for (gi = 0; gi < NUM_VREGS; gi++) begin : g_vreg_sel
      assign vreg_wr_sel[gi] = update_fire && decoded_vreg_write_enable && (vd_index == VA_W'(gi));
    end
  endgenerate

  // Scalar register file and block_id mirror
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_GPR; i++) gpr_reg[i] <= 8'h00;
      bid_reg <= 8'h00;
    end else if (enable) begin
      for (int i = 0; i < NUM_GPR; i++) begin
        if (gpr_wr_sel[i]) gpr_reg[i] <= wb_data;
      end
      bid_reg <= block_id;
    end
  end

  // Vector register file; whole registers are written, never individual lanes
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_VREGS; i++) vreg_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_VREGS; i++) begin
        if (vreg_wr_sel[i]) vreg_reg[i] <= vwb_data;
      end
    end
  end

  // Operand latches, refreshed only in REQUEST and held otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      rs_reg   <= 8'h00;
      rt_reg   <= 8'h00;
      v_rs_reg <= '0;
      v_rt_reg <= '0;
    end else if (read_fire) begin
      rs_reg   <= rs_next;
      rt_reg   <= rt_next;
      v_rs_reg <= v_rs_next;
      v_rt_reg <= v_rt_next;
    end
  end

  assign rs   = rs_reg;
  assign rt   = rt_reg;
  assign v_rs = v_rs_reg;
  assign v_rt = v_rt_reg;

endmodule

// File: tb/tb_thread_register_file.sv
// Randomized and directed bench for thread_register_file with an architectural reference model.
module tb_thread_register_file;

  localparam int TPB = 4;
  localparam int TID = 2;
  localparam int VS  = 4;
  localparam int NV  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, enable;
  logic [7:0]    block_id;
  logic [2:0]    core_state;
  logic [3:0]    rd_a, rs_a, rt_a;
  logic          we, vwe, vmux;
  logic [1:0]    mux;
  logic [7:0]    imm, alu, lsu;
  logic [8*VS-1:0] valu, vlsu;
  logic [7:0]    rs, rt;
  logic [8*VS-1:0] v_rs, v_rt;

  thread_register_file #(
    .THREADS_PER_BLOCK(TPB), .THREAD_ID(TID), .Vector_Size(VS), .NUM_VREGS(NV)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .block_id(block_id), .core_state(core_state),
    .decoded_rd_address(rd_a), .decoded_rs_address(rs_a), .decoded_rt_address(rt_a),
    .decoded_reg_write_enable(we), .decoded_reg_input_mux(mux), .decoded_immediate(imm),
    .decoded_vreg_write_enable(vwe), .decoded_vreg_input_mux(vmux),
    .alu_out(alu), .lsu_out(lsu), .v_alu_out(valu), .v_lsu_out(vlsu),
    .rs(rs), .rt(rt), .v_rs(v_rs), .v_rt(v_rt)
  );

  int total = 0;
  int bad = 0;

  // Reference model: architectural register contents and operand latches
  logic [7:0]      m_r [0:15];
  logic [8*VS-1:0] m_v [0:NV-1];
  logic [7:0]      m_rs, m_rt;
  logic [8*VS-1:0] m_vrs, m_vrt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Apply the architectural effect of one clock edge to the model
  task automatic model_step();
    if (reset) begin
      for (int i = 0; i < 16; i++) m_r[i] = 8'h00;
      m_r[14] = 8'(TPB);
      m_r[15] = 8'(TID);
      for (int i = 0; i < NV; i++) m_v[i] = '0;
      m_rs = 0; m_rt = 0; m_vrs = 0; m_vrt = 0;
    end else if (enable) begin
      if (core_state == 3'b011) begin
        m_rs  = m_r[rs_a];
        m_rt  = m_r[rt_a];
        m_vrs = m_v[rs_a % NV];
        m_vrt = m_v[rt_a % NV];
      end
      if (core_state == 3'b110) begin
        if (we && rd_a < 13 && mux != 2'b11)
          m_r[rd_a] = (mux == 2'b00) ? alu : (mux == 2'b01) ? lsu : imm;
        if (vwe) m_v[rd_a % NV] = vmux ? vlsu : valu;
      end
      m_r[13] = block_id;
    end
  endtask

  // One clock: advance the model, then compare all outputs just after the edge
  task automatic cycle(input string what);
    @(posedge clk);
    model_step();
    #1;
    $display("txn %s st=%0d en=%0d rst=%0d rs=%h rt=%h v_rs=%h v_rt=%h",
             what, core_state, enable, reset, rs, rt, v_rs, v_rt);
    check_val("rs", 32'(rs), 32'(m_rs));
    check_val("rt", 32'(rt), 32'(m_rt));
    check_val("v_rs", v_rs, m_vrs);
    check_val("v_rt", v_rt, m_vrt);
  endtask

  task automatic idle_ctl();
    core_state = 3'b000; we = 0; vwe = 0; mux = 0; vmux = 0;
  endtask

  task automatic request(input logic [3:0] a, input logic [3:0] b);
    core_state = 3'b011; rs_a = a; rt_a = b;
    cycle("request");
    idle_ctl();
  endtask

  task automatic update_s(input logic [3:0] d, input logic [1:0] m, input logic [7:0] v);
    core_state = 3'b110; rd_a = d; we = 1; mux = m; alu = v; lsu = v; imm = v;
    cycle("update");
    idle_ctl();
  endtask

  initial begin
    reset = 1; enable = 1; block_id = 0; rd_a = 0; rs_a = 0; rt_a = 0;
    imm = 0; alu = 0; lsu = 0; valu = 0; vlsu = 0;
    idle_ctl();
    cycle("reset");
    cycle("reset");
    reset = 0;
    check_val("rst_rs", 32'(rs), 32'h0);
    check_val("rst_vrs", v_rs, 32'h0);

    request(4'd15, 4'd14);
    check_val("tid", 32'(rs), 32'd2);
    check_val("tpb", 32'(rt), 32'd4);

    update_s(4'd3, 2'b00, 8'h5A);
    request(4'd3, 4'd0);
    check_val("alu_wb", 32'(rs), 32'h5A);

    update_s(4'd4, 2'b10, 8'h11);
    request(4'd4, 4'd3);
    check_val("imm_wb", 32'(rs), 32'h11);

    update_s(4'd14, 2'b10, 8'hFF);
    request(4'd14, 4'd14);
    check_val("ro_r14", 32'(rs), 32'd4);

    update_s(4'd5, 2'b11, 8'h33);
    request(4'd5, 4'd5);
    check_val("mux11", 32'(rs), 32'h0);

    block_id = 8'd7;
    cycle("bid");
    cycle("bid");
    request(4'd13, 4'd0);
    check_val("r13", 32'(rs), 32'd7);

    core_state = 3'b101; rd_a = 4'd6; we = 1; mux = 2'b00; alu = 8'hAA;
    cycle("exec_we");
    idle_ctl();
    request(4'd6, 4'd6);
    check_val("exec_nowr", 32'(rs), 32'h0);

    core_state = 3'b110; rd_a = 4'd5; vwe = 1; vmux = 1; vlsu = 32'h04030201; valu = 32'hDEADBEEF;
    we = 1; mux = 2'b01; lsu = 8'h09;
    cycle("update_vec");
    idle_ctl();
    request(4'd1, 4'd5);
    check_val("v_rs_v1", v_rs, 32'h04030201);
    check_val("v_rt_v1", v_rt, 32'h04030201);
    check_val("lsu_wb", 32'(rt), 32'h09);

    enable = 0;
    update_s(4'd7, 2'b00, 8'h77);
    request(4'd7, 4'd0);
    check_val("dis_hold", 32'(rt), 32'h09);
    enable = 1;
    request(4'd7, 4'd7);
    check_val("dis_nowr", 32'(rs), 32'h0);

    reset = 1;
    update_s(4'd8, 2'b00, 8'h88);
    reset = 0;
    request(4'd8, 4'd15);
    check_val("rst_lost", 32'(rs), 32'h0);
    check_val("rst_tid", 32'(rt), 32'd2);

    // Randomized traffic across all states, with occasional disable and reset
    for (int n = 0; n < 600; n++) begin
      reset      = ($urandom_range(0, 99) < 2);
      enable     = ($urandom_range(0, 9) != 0);
      core_state = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) core_state = ($urandom_range(0, 1) == 1) ? 3'b011 : 3'b110;
      block_id = 8'($urandom);
      rd_a = 4'($urandom); rs_a = 4'($urandom); rt_a = 4'($urandom);
      we = 1'($urandom); vwe = 1'($urandom); vmux = 1'($urandom);
      mux = 2'($urandom); imm = 8'($urandom); alu = 8'($urandom); lsu = 8'($urandom);
      valu = $urandom; vlsu = $urandom;
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
